// File: rtl/sprite_pkg.sv
// Constants and VGA timing bundle shared by the sprite overlay stages.
package sprite_pkg;

  localparam int XRES  = 640;
  localparam int YRES  = 480;
  localparam int HC_W  = 10;
  localparam int VC_W  = 10;
  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] ALPHA = 24'hA3_49_A4;

  typedef struct packed {
    logic [HC_W-1:0]  hcount;
    logic [VC_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             blnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  localparam int VGA_W = HC_W + VC_W + 3 + RGB_W;

  function automatic logic [6:0] clamp_height(input logic [6:0] h, input int h_max);
    if (int'(h) > h_max) return 7'(h_max);
    return h;
  endfunction

endpackage

// File: rtl/sprite_overlay_anim_vga_delay_line.sv
// D-stage register delay with asynchronous reset; D must be at least 1.
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[D-1];

endmodule

// File: rtl/sprite_overlay_anim.sv
// Animated, blinking sprite overlay for the VGA timing chain; geometry is latched
// at each vsync rising edge so a frame is never drawn with mixed settings.
module sprite_overlay_anim
  import sprite_pkg::*;
#(
  parameter int SPR_W     = 40,
  parameter int SPR_H_MAX = 80,
  parameter int FRAMES    = 4,
  parameter int ROM_LAT   = 1,
  parameter int ADDR_W    = 14,
  parameter int ANIM_DIV  = 6,
  parameter int BLINK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        xpos,
  input  logic [8:0]        ypos,
  input  logic [6:0]        height,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              blink_en,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_data,
  output logic [HC_W-1:0]   hcount_out,
  output logic [VC_W-1:0]   vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam int FIDX_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TICK_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int BLNK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FRAME_WORDS = SPR_W * SPR_H_MAX;

  logic              vsync_in_q;
  logic              vsync_rise;
  logic [9:0]        xpos_s_q;
  logic [8:0]        ypos_s_q;
  logic [6:0]        h_s_q;
  logic              flip_s_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [FIDX_W-1:0] frame_idx_q, frame_idx_d;
  logic [BLNK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              visible_q, visible_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit;

  assign vsync_rise = vsync_in & ~vsync_in_q;

  // Frame counters advance only on vsync_rise so the whole frame sees one state.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    frame_idx_d = frame_idx_q;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (vsync_rise) begin
      if (!anim_en) begin
        tick_cnt_d  = '0;
        frame_idx_d = '0;
      end else if (tick_cnt_q == TICK_W'(ANIM_DIV - 1)) begin
        tick_cnt_d  = '0;
        frame_idx_d = (frame_idx_q == FIDX_W'(FRAMES - 1)) ? '0 : frame_idx_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      if (!blink_en) begin
        blink_cnt_d = '0;
        visible_d   = 1'b1;
      end else if (blink_cnt_q == BLNK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 0: hit test and ROM address, 11-bit unsigned so nothing wraps.
  logic [10:0] vc_x, hc_x, ys, x_lo, x_hi, y_lo, y_hi, row, col, col_eff;

  always_comb begin
    vc_x    = {1'b0, vcount_in};
    hc_x    = {1'b0, hcount_in};
    ys      = 11'(YRES - 1) - vc_x;
    x_lo    = {1'b0, xpos_s_q};
    x_hi    = x_lo + 11'(SPR_W);
    y_lo    = {2'b0, ypos_s_q};
    y_hi    = y_lo + {4'b0, h_s_q};
    hit     = (vc_x < 11'(YRES)) && (ys >= y_lo) && (ys < y_hi) &&
              (hc_x >= x_lo) && (hc_x < x_hi);
    row     = y_hi - 11'd1 - ys;
    col     = hc_x - x_lo;
    col_eff = flip_s_q ? (11'(SPR_W - 1) - col) : col;
    rom_addr_d = ADDR_W'(frame_idx_q) * ADDR_W'(FRAME_WORDS)
               + ADDR_W'(row) * ADDR_W'(SPR_W)
               + ADDR_W'(col_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_in_q  <= 1'b0;
      xpos_s_q    <= '0;
      ypos_s_q    <= '0;
      h_s_q       <= '0;
      flip_s_q    <= 1'b0;
      tick_cnt_q  <= '0;
      frame_idx_q <= '0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      rom_addr_q  <= '0;
    end else begin
      vsync_in_q <= vsync_in;
      if (vsync_rise) begin
        xpos_s_q <= xpos;
        ypos_s_q <= ypos;
        h_s_q    <= clamp_height(height, SPR_H_MAX);
        flip_s_q <= flip_h;
      end
      tick_cnt_q  <= tick_cnt_d;
      frame_idx_q <= frame_idx_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
      // On a miss the stale address is harmless: the delayed hit masks it.
      if (hit) rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr = rom_addr_q;

  // Timing, background colour, hit and visible ride together until rom_data is valid.
  vga_t             vga_in, vga_dl, out_d, out_q;
  logic [VGA_W+1:0] dl_d, dl_q;
  logic             hit_dl, vis_dl;

  assign vga_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, blnk: blnk_in, rgb: rgb_in};
  assign dl_d   = {vga_in, hit, visible_q};

  vga_delay_line #(
    .W (VGA_W + 2),
    .D (ROM_LAT + 1)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (dl_d),
    .q_o (dl_q)
  );

  assign vga_dl = vga_t'(dl_q[VGA_W+1:2]);
  assign hit_dl = dl_q[1];
  assign vis_dl = dl_q[0];

  always_comb begin
    out_d = vga_dl;
    if (hit_dl && vis_dl && (rom_data != ALPHA)) out_d.rgb = rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign blnk_out   = out_q.blnk;
  assign rgb_out    = out_q.rgb;

endmodule
